// File: rtl/dmx_pry_pkg.sv
// -----------------------------------------------------------------------------
// dmx_pry_pkg
// Shared helpers for the priority demultiplexer.
//   sat_inc : saturating increment. Operands are carried at SAT_W bits so a
//             single function serves any counter width up to SAT_W; the caller
//             passes its own maximum value and truncates the result.
// -----------------------------------------------------------------------------
package dmx_pry_pkg;

   localparam int unsigned SAT_W = 64;

   function automatic logic [SAT_W-1:0] sat_inc(input logic [SAT_W-1:0] i_val,
                                                input logic [SAT_W-1:0] i_max);
      return (i_val >= i_max) ? i_val : i_val + SAT_W'(1);
   endfunction

endpackage

// File: rtl/pry_oht.sv
// -----------------------------------------------------------------------------
// pry_oht
// Combinational highest-set-bit encoder.
// Ports:
//   i_req [WIDTH] : request vector
//   o_oht [WIDTH] : one-hot of the highest-index set bit of i_req ('0 if none)
//   o_any         : at least one bit of i_req is set
// -----------------------------------------------------------------------------
module pry_oht #(
   parameter int unsigned WIDTH = 32
) (
   input  logic [WIDTH-1:0] i_req,
   output logic [WIDTH-1:0] o_oht,
   output logic             o_any
);

   // Ascending scan: a later (higher) set bit overrides any earlier choice.
   always_comb begin
      o_oht = '0;
      for (int i = 0; i < int'(WIDTH); i++) begin
         if (i_req[i]) begin
            o_oht    = '0;
            o_oht[i] = 1'b1;
         end
      end
   end

   assign o_any = |i_req;

endmodule

// File: rtl/dmx_pry_reg.sv
// -----------------------------------------------------------------------------
// dmx_pry_reg
// Priority demultiplexer with a one-entry output register per lane. Each
// accepted transfer goes to the highest-index lane that is enabled in i_pry
// and free (empty, or draining this cycle). Transfers with an empty mask are
// accepted, discarded and counted in a saturating drop counter.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_vld / i_rdy   : input handshake (i_rdy is combinational, no i_vld path)
//   i_pry [WIDTH]   : destination enable mask
//   i_dat           : input payload (DAT_T)
//   o_vld [WIDTH]   : per-lane output valid
//   o_rdy [WIDTH]   : per-lane output ready
//   o_dat [WIDTH]   : per-lane output payload (unpacked array of DAT_T)
//   drp_cnt [CNT_W] : number of dropped transfers, saturating
// -----------------------------------------------------------------------------
module dmx_pry_reg
   import dmx_pry_pkg::*;
#(
   parameter type         DAT_T = logic [4-1:0],
   parameter int unsigned WIDTH = 32,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_vld,
   output logic             i_rdy,
   input  logic [WIDTH-1:0] i_pry,
   input  DAT_T             i_dat,
   output logic [WIDTH-1:0] o_vld,
   input  logic [WIDTH-1:0] o_rdy,
   output DAT_T             o_dat [WIDTH-1:0],
   output logic [CNT_W-1:0] drp_cnt
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   logic [WIDTH-1:0] r_vld;
   DAT_T             r_dat [WIDTH-1:0];
   logic [CNT_W-1:0] r_drp_cnt;

   logic [WIDTH-1:0] w_fre;
   logic [WIDTH-1:0] w_cnd;
   logic [WIDTH-1:0] w_sel;
   logic             w_any;
   logic             w_pry_zero;
   logic [WIDTH-1:0] w_ld;
   logic             w_drp;

   // A lane that drains this cycle counts as free, so it can be reloaded
   // without a bubble.
   assign w_fre      = ~r_vld | o_rdy;
   assign w_cnd      = i_pry & w_fre;
   assign w_pry_zero = (i_pry == '0);

   pry_oht #(
      .WIDTH (WIDTH)
   ) u_pry_oht (
      .i_req (w_cnd),
      .o_oht (w_sel),
      .o_any (w_any)
   );

   // An empty mask is always accepted (and dropped).
   assign i_rdy = w_any || w_pry_zero;

   // w_sel is '0 for an empty mask, so a drop never loads a lane.
   assign w_ld  = (i_vld && i_rdy) ? w_sel : '0;
   assign w_drp = i_vld && w_pry_zero;

   // Per-lane output registers; load takes precedence over drain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_vld <= '0;
         for (int i = 0; i < int'(WIDTH); i++) begin
            r_dat[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(WIDTH); i++) begin
            if (w_ld[i]) begin
               r_vld[i] <= 1'b1;
               r_dat[i] <= i_dat;
            end else if (o_rdy[i]) begin
               r_vld[i] <= 1'b0;
            end
         end
      end
   end

   // Drop counter, holds at its maximum.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_drp_cnt <= '0;
      end else if (w_drp) begin
         r_drp_cnt <= CNT_W'(sat_inc(SAT_W'(r_drp_cnt), SAT_W'(CNT_MAX)));
      end
   end

   assign o_vld   = r_vld;
   assign o_dat   = r_dat;
   assign drp_cnt = r_drp_cnt;

endmodule

// File: tb/tb_dmx_pry_reg.sv
// -----------------------------------------------------------------------------
// tb_dmx_pry_reg
// Scoreboard bench for dmx_pry_reg with WIDTH=4, CNT_W=2, 4-bit payload.
// The driver applies inputs on the falling edge, predicts i_rdy / lane choice
// from a lane-occupancy model and pushes accepted payloads into per-lane
// queues. A separate monitor pops a lane's queue whenever that lane presents
// a completed output handshake and compares the payload.
// -----------------------------------------------------------------------------
module tb_dmx_pry_reg;

   localparam int W  = 4;
   localparam int CW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          i_vld;
   logic          i_rdy;
   logic [W-1:0]  i_pry;
   logic [3:0]    i_dat;
   logic [W-1:0]  o_vld;
   logic [W-1:0]  o_rdy;
   logic [3:0]    o_dat [W-1:0];
   logic [CW-1:0] drp_cnt;

   int checks   = 0;
   int failures = 0;

   // Reference state: which lanes hold data, expected payloads, drop count.
   logic [W-1:0]  m_vld;
   logic [3:0]    q [W][$];
   int            m_cnt;

   always #5 clk = ~clk;

   dmx_pry_reg #(
      .DAT_T (logic [3:0]),
      .WIDTH (W),
      .CNT_W (CW)
   ) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_vld   (i_vld),
      .i_rdy   (i_rdy),
      .i_pry   (i_pry),
      .i_dat   (i_dat),
      .o_vld   (o_vld),
      .o_rdy   (o_rdy),
      .o_dat   (o_dat),
      .drp_cnt (drp_cnt)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic clr_model();
      m_vld = '0;
      m_cnt = 0;
      for (int i = 0; i < W; i++) q[i].delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      i_vld = 1'b0; i_pry = '0; i_dat = '0; o_rdy = '0;
      clr_model();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   // One cycle of stimulus plus model prediction.
   task automatic step(input logic v, input logic [W-1:0] p, input logic [3:0] d,
                       input logic [W-1:0] r);
      int lane;
      logic exp_rdy;
      @(negedge clk);
      i_vld = v; i_pry = p; i_dat = d; o_rdy = r;
      #1;
      chk("o_vld", 32'(o_vld), 32'(m_vld));
      chk("drp_cnt", 32'(drp_cnt), 32'(m_cnt));
      lane = -1;
      for (int i = W - 1; i >= 0; i--) begin
         if (p[i] && (!m_vld[i] || r[i])) begin
            lane = i;
            break;
         end
      end
      exp_rdy = (lane >= 0) || (p == '0);
      chk("i_rdy", 32'(i_rdy), 32'(exp_rdy));
      for (int i = 0; i < W; i++) if (m_vld[i] && r[i]) m_vld[i] = 1'b0;
      if (v && exp_rdy) begin
         if (p == '0) begin
            m_cnt = (m_cnt >= (1 << CW) - 1) ? m_cnt : m_cnt + 1;
         end else begin
            m_vld[lane] = 1'b1;
            q[lane].push_back(d);
         end
      end
   endtask

   // Monitor: runs after the driver has settled inputs for this cycle.
   initial begin
      forever begin
         @(negedge clk);
         #2;
         if (rst_n === 1'b1) begin
            for (int i = 0; i < W; i++) begin
               if (o_vld[i] && o_rdy[i]) begin
                  if (q[i].size() == 0) begin
                     chk($sformatf("lane%0d_unexpected_valid", i), 32'(o_vld[i]), 32'(0));
                  end else begin
                     chk($sformatf("lane%0d_dat", i), 32'(o_dat[i]), 32'(q[i].pop_front()));
                  end
               end
            end
         end
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog actual=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst_n = 1'b0;
      i_vld = 1'b0; i_pry = '0; i_dat = '0; o_rdy = '0;
      clr_model();
      do_reset();

      // Reset state
      #1;
      chk("rst_o_vld", 32'(o_vld), 32'(0));
      chk("rst_drp_cnt", 32'(drp_cnt), 32'(0));
      for (int i = 0; i < W; i++) chk($sformatf("rst_o_dat%0d", i), 32'(o_dat[i]), 32'(0));

      // Directed scenarios
      step(1'b0, 4'b0001, 4'h0, 4'b0000);   // i_rdy=1 with empty lanes
      step(1'b1, 4'b0110, 4'hA, 4'b0000);   // lane 2 <- A
      step(1'b1, 4'b0110, 4'hB, 4'b0000);   // lane 2 stalled, lane 1 <- B
      chk("dir_o_dat2_A", 32'(o_dat[2]), 32'(4'hA));
      step(1'b1, 4'b0100, 4'hC, 4'b0000);   // only lane 2 enabled and stalled: i_rdy=0
      chk("dir_o_dat1_B", 32'(o_dat[1]), 32'(4'hB));
      chk("dir_o_dat2_held", 32'(o_dat[2]), 32'(4'hA));
      step(1'b1, 4'b0100, 4'hC, 4'b0100);   // drain A, reload C in the same cycle
      step(1'b0, 4'b0000, 4'h0, 4'b0000);
      chk("dir_o_dat2_C", 32'(o_dat[2]), 32'(4'hC));
      chk("dir_o_vld_0110", 32'(o_vld), 32'(4'b0110));
      for (int k = 0; k < 4; k++) step(1'b1, 4'b0000, 4'(k), 4'b0000);  // drops 1,2,3,3
      step(1'b0, 4'b0000, 4'h0, 4'b0000);
      chk("dir_drp_sat", 32'(drp_cnt), 32'(3));
      step(1'b0, 4'b0000, 4'h0, 4'b1111);   // drain B and C
      step(1'b0, 4'b0000, 4'h0, 4'b0000);

      // Reset mid-cycle with lanes 0 and 3 valid and drp_cnt=2
      do_reset();
      step(1'b1, 4'b0000, 4'h1, 4'b0000);
      step(1'b1, 4'b0000, 4'h2, 4'b0000);
      step(1'b1, 4'b1000, 4'h5, 4'b0000);
      step(1'b1, 4'b0001, 4'h6, 4'b0000);
      step(1'b0, 4'b0000, 4'h0, 4'b0000);
      chk("pre_rst_o_vld", 32'(o_vld), 32'(4'b1001));
      chk("pre_rst_drp", 32'(drp_cnt), 32'(2));
      #2;
      rst_n = 1'b0;
      #1;
      chk("async_rst_o_vld", 32'(o_vld), 32'(0));
      chk("async_rst_drp", 32'(drp_cnt), 32'(0));
      chk("async_rst_o_dat3", 32'(o_dat[3]), 32'(0));
      clr_model();
      @(negedge clk);
      rst_n = 1'b1;

      // Randomized traffic
      for (int n = 0; n < 3000; n++) begin
         step(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
              4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      end

      // Drain everything and confirm nothing was left behind
      for (int n = 0; n < 4; n++) step(1'b0, 4'b0000, 4'h0, 4'b1111);
      for (int i = 0; i < W; i++) chk($sformatf("lane%0d_left", i), 32'(q[i].size()), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
